pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch/execute controller for the 8-bit program counter of the soft CPU. It owns the PC register and sequences it through reset, instruction fetch with a request/acknowledge handshake to instruction memory, and the post-execute update. The update is one of increment, jump load or halt. It sits between the instruction memory port and the decode/execute stage, replacing free-running PC increment with a single synchronous controller.

## Interface
Parameters:
- PC_WIDTH, 8, width of PC and memory address
- INSTR_WIDTH, 16, width of fetched instruction word
- RESET_PC, 0, PC value loaded by reset
- ACK_TIMEOUT, 15, max FETCH cycles without ack before fault; 0 disables the timeout

Ports:
- i_clk  in  1  single clock; all state changes on rising edge
- i_reset  in  1  reset, asynchronous, active-high
- i_run  in  1  enable; start or continue sequencing
- i_memAck  in  1  instruction memory acknowledge; i_memData valid when high
- i_memData  in  INSTR_WIDTH  fetched instruction word
- i_stall  in  1  execute stage busy; hold in EXEC
- i_jump  in  1  load i_target as next PC (sampled in EXEC)
- i_target  in  PC_WIDTH  jump destination
- i_halt  in  1  stop after current instruction (sampled in EXEC)
- o_pc  out  PC_WIDTH  current PC
- o_memReq  out  1  fetch request
- o_memAddr  out  PC_WIDTH  fetch address, equals o_pc
- o_instr  out  INSTR_WIDTH  last fetched instruction
- o_instrValid  out  1  one-cycle pulse: o_instr newly loaded
- o_halted  out  1  in HALT state
- o_fault  out  1  halted due to ack timeout

## Operation
- States: IDLE, FETCH, EXEC, HALT. State is encoded in registers; all outputs are registered or decoded from state.
- Reset (async, any state, mid-handshake included):
  - state=IDLE, o_pc=RESET_PC.
  - o_memReq=0, o_instr=0, o_instrValid=0, o_halted=0, o_fault=0.
  - Timeout counter=0.
- IDLE: o_memReq=0. i_run=1 -> FETCH; else stay.
- FETCH:
  - o_memReq=1, o_memAddr=o_pc.
  - i_memAck=1 -> o_instr<=i_memData, o_instrValid<=1, counter<=0, -> EXEC.
  - Else counter increments. If ACK_TIMEOUT!=0 and counter==ACK_TIMEOUT-1 -> HALT with o_fault<=1.
  - i_run is ignored in FETCH; an outstanding fetch always completes or times out.
- EXEC: o_memReq=0. o_instrValid is high only in the first EXEC cycle. Resolution:
  - i_stall=1: hold PC and state. i_jump and i_halt are ignored.
  - else i_halt=1: PC unchanged, -> HALT (o_fault stays 0).
  - else i_jump=1: o_pc<=i_target.
  - else: o_pc<=o_pc+1, modulo 2^PC_WIDTH (0xFF -> 0x00, no flag).
  - After a jump or increment: i_run=1 -> FETCH, i_run=0 -> IDLE.
- HALT: o_memReq=0, o_halted=1, PC frozen. Only reset exits HALT.
- i_memAck outside FETCH is ignored; o_instr holds its value.

## Timing
- Each signal's timing relative to the rising edge of i_clk:
  - o_memReq: asserts the cycle after the edge that enters FETCH.
  - i_memAck: sampled every cycle in FETCH, including the first, so zero-wait memory is allowed.
  - o_memReq: drops the cycle after the ack edge.
- Minimum instruction period is 2 cycles (FETCH with immediate ack, then EXEC with i_stall=0).
- o_pc updates on the edge that leaves EXEC and is valid in the following FETCH cycle as o_memAddr.
- Timeout: with ACK_TIMEOUT=N and no ack, o_memReq is high for exactly N cycles. HALT and o_fault take effect after the Nth.
- Reset assertion clears outputs immediately, not at a clock edge. Reset release takes effect at the first clock edge.

## Test plan
- Reset, i_run=1, memory acks each request immediately with data 0x1000+addr, no stall, no jump -> o_memAddr sequence 0x00,0x01,0x02… The instruction period is 2 cycles. o_instrValid pulses once per fetch.
- PC wrap: i_jump with i_target=0xFE, then plain increments -> fetch addresses 0xFE,0xFF,0x00,0x01. No fault.
- Delayed ack: 3 wait cycles per fetch -> o_memReq held 4 cycles at a stable address. Then i_stall=1 for 5 cycles in EXEC with i_jump=1 -> PC unchanged until stall drops, then loads i_target.
- Halt: i_halt=1 and i_jump=1 together in EXEC at PC=0x10 -> HALT, o_halted=1, o_pc=0x10, o_fault=0. Further i_run and i_memAck have no effect.
- Timeout: ACK_TIMEOUT=15, never ack -> o_memReq high 15 cycles, then o_halted=1 and o_fault=1, o_pc unchanged.
- Async reset mid-FETCH (ack pending) and mid-EXEC -> outputs return to reset values without a clock edge. After release with i_run=1, the first fetch address is RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch/execute controller owning the soft-CPU program counter.
// Fetches via a req/ack handshake, then increments, jumps or halts after execute.
module pc_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int RESET_PC    = 0,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_run,
  input  logic                   i_memAck,
  input  logic [INSTR_WIDTH-1:0] i_memData,
  input  logic                   i_stall,
  input  logic                   i_jump,
  input  logic [PC_WIDTH-1:0]    i_target,
  input  logic                   i_halt,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic                   o_memReq,
  output logic [PC_WIDTH-1:0]    o_memAddr,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic                   o_instrValid,
  output logic                   o_halted,
  output logic                   o_fault
);

  // state   | meaning
  // S_IDLE  | waiting for i_run
  // S_FETCH | memory request outstanding, counting wait cycles
  // S_EXEC  | instruction held for execute; resolves stall/halt/jump/increment
  // S_HALT  | stopped (halt or ack timeout); only reset leaves
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic                   fault_q, fault_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    fault_d = fault_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (i_run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (i_memAck) begin
          instr_d = i_memData;
          valid_d = 1'b1;
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // Counter value N-1 marks the Nth unanswered request cycle.
          if ((ACK_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (!i_stall) begin
          if (i_halt) begin
            state_d = S_HALT;
          end else begin
            pc_d    = i_jump ? i_target : pc_q + PC_WIDTH'(1);
            state_d = i_run ? S_FETCH : S_IDLE;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      pc_q    <= PC_WIDTH'(RESET_PC);
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_pc         = pc_q;
  assign o_memAddr    = pc_q;
  assign o_memReq     = (state_q == S_FETCH);
  assign o_halted     = (state_q == S_HALT);
  assign o_instr      = instr_q;
  assign o_instrValid = valid_q;
  assign o_fault      = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: transaction-level PC model with randomized
// wait, stall, jump and run patterns, plus halt, timeout and async reset scenarios.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run, ack, stall, jump, halt;
  logic [15:0] mdata;
  logic [7:0]  target;
  logic [7:0]  pc, maddr;
  logic        mreq, ivalid, halted, fault;
  logic [15:0] instr;

  int checks = 0;
  int failures = 0;
  int exp_pc;
  logic [15:0] exp_instr;

  pc_sequencer dut (
    .i_clk(clk), .i_reset(rst), .i_run(run), .i_memAck(ack), .i_memData(mdata),
    .i_stall(stall), .i_jump(jump), .i_target(target), .i_halt(halt),
    .o_pc(pc), .o_memReq(mreq), .o_memAddr(maddr), .o_instr(instr),
    .o_instrValid(ivalid), .o_halted(halted), .o_fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reset, then release with i_run=1; returns at the negedge of the first FETCH cycle.
  task automatic start();
    rst = 1'b1; run = 1'b0; ack = 1'b0; stall = 1'b0; jump = 1'b0; halt = 1'b0;
    mdata = '0; target = '0;
    @(negedge clk);
    rst = 1'b0; run = 1'b1;
    exp_pc = 0; exp_instr = '0;
    @(negedge clk);
  endtask

  task automatic do_fetch(input int wait_n);
    logic [15:0] d;
    d = 16'($urandom);
    for (int k = 0; k <= wait_n; k++) begin
      checks++;
      if (mreq !== 1'b1 || maddr !== 8'(exp_pc)) begin
        failures++;
        $display("FAIL fetch_req: memReq=%b addr=%h, required memReq=1 addr=%h", mreq, maddr, 8'(exp_pc));
      end
      ack   = (k == wait_n);
      mdata = (k == wait_n) ? d : 16'($urandom);
      run   = 1'($urandom);
      @(negedge clk);
    end
    ack = 1'b0;
    exp_instr = d;
    checks++;
    if (ivalid !== 1'b1 || instr !== exp_instr || mreq !== 1'b0) begin
      failures++;
      $display("FAIL fetch_done: valid=%b instr=%h memReq=%b, required valid=1 instr=%h memReq=0",
               ivalid, instr, mreq, exp_instr);
    end
  endtask

  task automatic do_exec(input int stall_n, input bit j, input logic [7:0] tgt, input bit h, input bit r);
    for (int s = 0; s < stall_n; s++) begin
      stall = 1'b1; jump = 1'($urandom); halt = 1'($urandom); target = 8'($urandom);
      ack = 1'($urandom); mdata = 16'($urandom);
      @(negedge clk);
      checks++;
      if (pc !== 8'(exp_pc) || ivalid !== 1'b0 || mreq !== 1'b0 || halted !== 1'b0 || instr !== exp_instr) begin
        failures++;
        $display("FAIL exec_stall: pc=%h valid=%b req=%b halted=%b instr=%h, required pc=%h valid=0 req=0 halted=0 instr=%h",
                 pc, ivalid, mreq, halted, instr, 8'(exp_pc), exp_instr);
      end
    end
    stall = 1'b0; ack = 1'b0; jump = j; target = tgt; halt = h; run = r;
    @(negedge clk);
    jump = 1'b0; halt = 1'b0;
    if (h) begin
      checks++;
      if (halted !== 1'b1 || pc !== 8'(exp_pc) || fault !== 1'b0 || mreq !== 1'b0) begin
        failures++;
        $display("FAIL exec_halt: halted=%b pc=%h fault=%b req=%b, required halted=1 pc=%h fault=0 req=0",
                 halted, pc, fault, mreq, 8'(exp_pc));
      end
    end else begin
      exp_pc = j ? int'(tgt) : (exp_pc + 1) % 256;
      checks++;
      if (pc !== 8'(exp_pc) || halted !== 1'b0 || ivalid !== 1'b0 || mreq !== r) begin
        failures++;
        $display("FAIL exec_update: pc=%h halted=%b valid=%b req=%b, required pc=%h halted=0 valid=0 req=%b",
                 pc, halted, ivalid, mreq, 8'(exp_pc), r);
      end
      if (!r) begin
        for (int n = 0; n < int'($urandom_range(0, 2)); n++) begin
          ack = 1'($urandom); mdata = 16'($urandom);
          @(negedge clk);
          checks++;
          if (mreq !== 1'b0 || pc !== 8'(exp_pc) || instr !== exp_instr) begin
            failures++;
            $display("FAIL idle_hold: req=%b pc=%h instr=%h, required req=0 pc=%h instr=%h",
                     mreq, pc, instr, 8'(exp_pc), exp_instr);
          end
        end
        ack = 1'b0; run = 1'b1;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; ack = 1'b0; stall = 1'b0; jump = 1'b0; halt = 1'b0;
    mdata = '0; target = '0;
    #2;
    checks++;
    if (pc !== 8'h00 || mreq !== 1'b0 || instr !== 16'h0 || ivalid !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: pc=%h req=%b instr=%h valid=%b halted=%b fault=%b, required all zero",
               pc, mreq, instr, ivalid, halted, fault);
    end
  endtask

  task automatic test_sequential();
    start();
    for (int i = 0; i < 8; i++) begin
      do_fetch(0);
      do_exec(0, 1'b0, 8'h00, 1'b0, 1'b1);
    end
  endtask

  task automatic test_wrap();
    start();
    do_fetch(0);
    do_exec(0, 1'b1, 8'hFE, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      do_fetch(0);
      do_exec(0, 1'b0, 8'h00, 1'b0, 1'b1);
    end
    checks++;
    if (fault !== 1'b0 || pc !== 8'h02) begin
      failures++;
      $display("FAIL wrap: pc=%h fault=%b, required pc=02 fault=0", pc, fault);
    end
  endtask

  task automatic test_delayed_stall();
    start();
    do_fetch(3);
    do_exec(5, 1'b1, 8'h55, 1'b0, 1'b1);
    do_fetch(3);
    do_exec(2, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    start();
    for (int i = 0; i < 40; i++) begin
      do_fetch(int'($urandom_range(0, 4)));
      do_exec(int'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), 1'b0, $urandom_range(0, 3) != 0);
    end
    do_fetch(int'($urandom_range(0, 4)));
    do_exec(int'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), 1'b1, 1'b1);
  endtask

  task automatic test_halt();
    start();
    do_fetch(0);
    do_exec(0, 1'b1, 8'h10, 1'b0, 1'b1);
    do_fetch(1);
    do_exec(0, 1'b1, 8'h33, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      run = 1'b1; ack = 1'b1; mdata = 16'($urandom);
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || pc !== 8'h10 || fault !== 1'b0 || mreq !== 1'b0 || instr !== exp_instr) begin
        failures++;
        $display("FAIL halt_hold: halted=%b pc=%h fault=%b req=%b instr=%h, required halted=1 pc=10 fault=0 req=0 instr=%h",
                 halted, pc, fault, mreq, instr, exp_instr);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    start();
    n = 0;
    while (mreq === 1'b1 && n < 40) begin
      n++;
      run = 1'($urandom);
      @(negedge clk);
    end
    checks++;
    if (n != 15) begin
      failures++;
      $display("FAIL timeout_len: memReq cycles=%0d, required 15", n);
    end
    checks++;
    if (halted !== 1'b1 || fault !== 1'b1 || pc !== 8'h00) begin
      failures++;
      $display("FAIL timeout_state: halted=%b fault=%b pc=%h, required halted=1 fault=1 pc=00", halted, fault, pc);
    end
  endtask

  task automatic test_async_reset();
    start();
    do_fetch(0);
    do_exec(0, 1'b1, 8'h5A, 1'b0, 1'b1);
    ack = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pc !== 8'h00 || mreq !== 1'b0 || instr !== 16'h0 || ivalid !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) begin
      failures++;
      $display("FAIL areset_fetch: pc=%h req=%b instr=%h valid=%b halted=%b fault=%b, required all zero",
               pc, mreq, instr, ivalid, halted, fault);
    end
    @(negedge clk);
    rst = 1'b0; run = 1'b1;
    exp_pc = 0; exp_instr = '0;
    @(negedge clk);
    checks++;
    if (mreq !== 1'b1 || maddr !== 8'h00) begin
      failures++;
      $display("FAIL areset_restart: req=%b addr=%h, required req=1 addr=00", mreq, maddr);
    end
    do_fetch(0);
    do_exec(0, 1'b1, 8'hA7, 1'b0, 1'b1);
    do_fetch(0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pc !== 8'h00 || mreq !== 1'b0 || instr !== 16'h0 || ivalid !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) begin
      failures++;
      $display("FAIL areset_exec: pc=%h req=%b instr=%h valid=%b halted=%b fault=%b, required all zero",
               pc, mreq, instr, ivalid, halted, fault);
    end
    @(negedge clk);
    rst = 1'b0; run = 1'b1;
    exp_pc = 0; exp_instr = '0;
    @(negedge clk);
    do_fetch(0);
    do_exec(0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wrap();
    test_delayed_stall();
    test_random();
    test_halt();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
